// File: rtl/note_line_prefetch_if.sv
// Glyph-ROM read port and line-buffer write port of the note line prefetcher.
// master = prefetcher side, slave = ROM / line-buffer side.
interface note_line_prefetch_if #(
  parameter int unsigned CW = 10,
  parameter int unsigned AW = 10
);
  logic [AW-1:0] rom_addr;
  logic [1:0]    rom_sel;
  logic          rom_pixel;
  logic          lb_we;
  logic [CW-1:0] lb_waddr;

  modport master (
    output rom_addr,
    output rom_sel,
    output lb_we,
    output lb_waddr,
    input  rom_pixel
  );

  modport slave (
    input  rom_addr,
    input  rom_sel,
    input  lb_we,
    input  lb_waddr,
    output rom_pixel
  );
endinterface

// File: rtl/note_line_prefetch.sv
// Scanline note-glyph scheduler: scans slots per line and streams glyph rows into the line buffer.
// Optional feature: define NOTE_MIRROR_EN to add per-slot horizontal glyph mirroring.
module note_line_prefetch #(
  parameter int unsigned NUM_SLOTS = 6,
  parameter int unsigned SPR_W     = 20,
  parameter int unsigned SPR_H     = 30,
  parameter int unsigned H_RES     = 640,
  parameter int unsigned CW        = 10,
  parameter int unsigned AW        = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   line_start,
  input  logic [CW-1:0]          line_y,
  input  logic [NUM_SLOTS-1:0]   slot_valid,
  input  logic [NUM_SLOTS*CW-1:0] slot_x,
  input  logic [NUM_SLOTS*CW-1:0] slot_y,
  input  logic [NUM_SLOTS*2-1:0] slot_type,
`ifdef NOTE_MIRROR_EN
  input  logic [NUM_SLOTS-1:0]   slot_mirror,
`endif
  note_line_prefetch_if.master   bus,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int unsigned IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StScan  = 2'd1;
  localparam logic [1:0] StFetch = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] ly_q, ly_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] x_q, x_d;
  logic [1:0]    type_q, type_d;
  logic [CW:0]   pipe_x_q, pipe_x_d;
  logic          pipe_v_q, pipe_v_d;
  logic          overrun_q;

  logic          cur_valid;
  logic [CW-1:0] cur_x, cur_y;
  logic [1:0]    cur_type;
  logic [CW:0]   diff;
  logic          hit, last_slot, last_col, fetching;
  logic [CW-1:0] col_eff;

`ifdef NOTE_MIRROR_EN
  logic mirror_q, mirror_d, cur_mirror;
`endif

  // Select the slot currently being scanned; inputs are sampled live.
  always_comb begin
    cur_valid = 1'b0;
    cur_x     = '0;
    cur_y     = '0;
    cur_type  = '0;
`ifdef NOTE_MIRROR_EN
    cur_mirror = 1'b0;
`endif
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_valid = slot_valid[i];
        cur_x     = slot_x[i*CW +: CW];
        cur_y     = slot_y[i*CW +: CW];
        cur_type  = slot_type[i*2 +: 2];
`ifdef NOTE_MIRROR_EN
        cur_mirror = slot_mirror[i];
`endif
      end
    end
  end

  // MSB of the widened subtract is the borrow, i.e. line_y < slot_y.
  assign diff      = {1'b0, ly_q} - {1'b0, cur_y};
  assign hit       = cur_valid & ~diff[CW] & (diff < (CW+1)'(SPR_H));
  assign last_slot = (idx_q == IW'(NUM_SLOTS - 1));
  assign last_col  = (col_q == CW'(SPR_W - 1));
  assign fetching  = (state_q == StFetch);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ly_d     = ly_q;
    row_d    = row_q;
    col_d    = col_q;
    x_d      = x_q;
    type_d   = type_q;
`ifdef NOTE_MIRROR_EN
    mirror_d = mirror_q;
`endif
    pipe_v_d = fetching;
    pipe_x_d = {1'b0, x_q} + {1'b0, col_q};

    case (state_q)
      StIdle: begin
        if (line_start) begin
          ly_d    = line_y;
          idx_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (hit) begin
          row_d   = diff[CW-1:0];
          x_d     = cur_x;
          type_d  = cur_type;
`ifdef NOTE_MIRROR_EN
          mirror_d = cur_mirror;
`endif
          col_d   = '0;
          state_d = StFetch;
        end else if (last_slot) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      StFetch: begin
        col_d = col_q + CW'(1);
        if (last_col) begin
          if (last_slot) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = StScan;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      ly_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      x_q       <= '0;
      type_q    <= '0;
`ifdef NOTE_MIRROR_EN
      mirror_q  <= 1'b0;
`endif
      pipe_x_q  <= '0;
      pipe_v_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ly_q      <= ly_d;
      row_q     <= row_d;
      col_q     <= col_d;
      x_q       <= x_d;
      type_q    <= type_d;
`ifdef NOTE_MIRROR_EN
      mirror_q  <= mirror_d;
`endif
      pipe_x_q  <= pipe_x_d;
      pipe_v_q  <= pipe_v_d;
      if (line_start && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
    end
  end

`ifdef NOTE_MIRROR_EN
  assign col_eff = mirror_q ? (CW'(SPR_W - 1) - col_q) : col_q;
`else
  assign col_eff = col_q;
`endif

  assign bus.rom_addr = fetching ? (AW'(row_q) * AW'(SPR_W) + AW'(col_eff)) : '0;
  assign bus.rom_sel  = fetching ? type_q : 2'b00;
  // Only set pixels are written; the line buffer ORs overlapping glyphs for free.
  assign bus.lb_we    = pipe_v_q & bus.rom_pixel & (pipe_x_q < (CW+1)'(H_RES));
  assign bus.lb_waddr = pipe_x_q[CW-1:0];

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign overrun = overrun_q;

endmodule
